// File: rtl/servo_ramp_sequencer.sv
// servo_ramp_sequencer
//   Accepts a target (x, y, z) angle triple over a valid/ready handshake and
//   ramps the three 7-bit servo commands toward it one LSB per step tick, so
//   the downstream PWM stage never sees a pose jump.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous reset, active low
//   tgt_x/tgt_y/tgt_z    requested angles (clamped to ANGLE_MAX on accept)
//   tgt_valid/tgt_ready  target handshake; ready only while idle
//   hold                 freeze the ramp (counter and positions) while high
//   x/y/z                current commanded angles, registered
//   busy                 move in progress
//   done                 one-cycle pulse when all axes reach their targets

// Per-axis helper: target clamp, one-LSB step toward target, arrival flag.
module servo_ramp_axis #(
  parameter logic [6:0] ANGLE_MAX = 7'd120
) (
  input  logic [6:0] pos_i,
  input  logic [6:0] tgt_i,
  input  logic [6:0] req_i,
  output logic [6:0] step_o,
  output logic [6:0] clamp_o,
  output logic       at_tgt_o
);
  assign at_tgt_o = (pos_i == tgt_i);
  assign clamp_o  = (req_i > ANGLE_MAX) ? ANGLE_MAX : req_i;

  // Targets are always <= ANGLE_MAX, so +/-1 never wraps.
  always_comb begin
    step_o = pos_i;
    if (pos_i < tgt_i)      step_o = pos_i + 7'd1;
    else if (pos_i > tgt_i) step_o = pos_i - 7'd1;
  end
endmodule

module servo_ramp_sequencer #(
  parameter int         STEP_DIV  = 500000,
  parameter logic [6:0] HOME      = 7'd64,
  parameter logic [6:0] ANGLE_MAX = 7'd120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] tgt_x,
  input  logic [6:0] tgt_y,
  input  logic [6:0] tgt_z,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic       hold,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic [6:0] z,
  output logic       busy,
  output logic       done
);
  localparam int NUM_AXES = 3;
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  // Axis index 0 = x, 1 = y, 2 = z.
  logic [NUM_AXES-1:0][6:0] pos_q, pos_d, tgt_q, tgt_d;
  logic [NUM_AXES-1:0][6:0] req, clamp, step;
  logic [NUM_AXES-1:0]      at_tgt;

  assign req = {tgt_z, tgt_y, tgt_x};

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    servo_ramp_axis #(.ANGLE_MAX(ANGLE_MAX)) u_axis (
      .pos_i   (pos_q[i]),
      .tgt_i   (tgt_q[i]),
      .req_i   (req[i]),
      .step_o  (step[i]),
      .clamp_o (clamp[i]),
      .at_tgt_o(at_tgt[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d   = clamp;
          cnt_d   = '0;
          state_d = MOVE;
        end
      end
      MOVE: begin
        // Arrival wins over hold, so a hold after the last step never delays done.
        if (&at_tgt) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          pos_d = step;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pos_q   <= {NUM_AXES{HOME}};
      tgt_q   <= {NUM_AXES{HOME}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
    end
  end

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q == MOVE);
  assign done      = done_q;
  assign x         = pos_q[0];
  assign y         = pos_q[1];
  assign z         = pos_q[2];
endmodule

// File: tb/tb_servo_ramp_sequencer.sv
module tb_servo_ramp_sequencer;
  localparam int SD = 4;
  localparam int HOME_A = 64;
  localparam int AMAX = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] tgt_x = '0, tgt_y = '0, tgt_z = '0;
  logic tgt_valid = 1'b0, hold = 1'b0;
  logic tgt_ready, busy, done;
  logic [6:0] x, y, z;

  int checks = 0;
  int errors = 0;
  int cur[3] = '{HOME_A, HOME_A, HOME_A};

  always #5 clk = ~clk;

  servo_ramp_sequencer #(.STEP_DIV(SD), .HOME(7'd64), .ANGLE_MAX(7'd120)) dut (
    .clk(clk), .rst(rst),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_z(tgt_z),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .hold(hold),
    .x(x), .y(y), .z(z), .busy(busy), .done(done)
  );

  // Position of an axis after `a` un-held step-counter cycles since accept.
  function automatic int ramp_pos(int s, int t, int a);
    int d, k;
    d = (t >= s) ? t - s : s - t;
    k = (a / SD < d) ? a / SD : d;
    return (t >= s) ? s + k : s - k;
  endfunction

  // Accept a target and follow the whole move cycle by cycle against the model.
  // Returns the edge index (relative to the accept edge) after which done is high.
  task automatic run_move(input int rx, input int ry, input int rz,
                          input int hold_from, input int hold_len, input int hold_pct,
                          input bit inject, input bit b2b, input string name,
                          output int done_n);
    int s[3], t[3], r[3], p[3];
    int a, n;
    bit mv, dexp, hnext, arrived;
    logic [23:0] expv, actv;
    r = '{rx, ry, rz};
    for (int i = 0; i < 3; i++) begin
      s[i] = cur[i];
      t[i] = (r[i] > AMAX) ? AMAX : r[i];
      p[i] = s[i];
    end
    if (!b2b) @(negedge clk);
    tgt_x = 7'(rx); tgt_y = 7'(ry); tgt_z = 7'(rz);
    tgt_valid = 1'b1;
    hold = 1'b0;
    checks++;
    if (tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept got %b exp 1", name, tgt_ready);
    end
    @(posedge clk);
    #1 tgt_valid = 1'b0;
    a = 0; n = 0; mv = 1'b1; dexp = 1'b0; done_n = -1;
    forever begin
      @(negedge clk);
      expv = {7'(p[0]), 7'(p[1]), 7'(p[2]), mv, dexp, ~mv};
      actv = {x, y, z, busy, done, tgt_ready};
      checks++;
      if (actv !== expv) begin
        errors++;
        $display("FAIL %s cyc %0d {x,y,z,busy,done,ready} got %h exp %h", name, n, actv, expv);
      end
      if (dexp) begin
        done_n = n;
        break;
      end
      if (n > 2000) begin
        errors++;
        $display("FAIL %s timeout got no done exp done", name);
        break;
      end
      hnext = ((n >= hold_from) && (n < hold_from + hold_len)) || ($urandom_range(99) < hold_pct);
      hold = hnext;
      if (inject && mv && $urandom_range(1) == 1) begin
        tgt_x = 7'd0; tgt_y = 7'd0; tgt_z = 7'd0; tgt_valid = 1'b1;
      end else begin
        tgt_valid = 1'b0;
      end
      // Model of the next edge.
      dexp = 1'b0;
      if (mv) begin
        arrived = (p[0] == t[0]) && (p[1] == t[1]) && (p[2] == t[2]);
        if (arrived) begin
          mv = 1'b0;
          dexp = 1'b1;
        end else if (!hnext) begin
          a++;
          for (int i = 0; i < 3; i++) p[i] = ramp_pos(s[i], t[i], a);
        end
      end
      n++;
    end
    hold = 1'b0;
    tgt_valid = 1'b0;
    for (int i = 0; i < 3; i++) cur[i] = p[i];
  endtask

  task automatic test_reset();
    logic [23:0] actv;
    #1 rst = 1'b0;
    #1;
    actv = {x, y, z, busy, done, tgt_ready};
    checks++;
    if (actv !== {7'd64, 7'd64, 7'd64, 3'b001}) begin
      errors++;
      $display("FAIL reset_no_clock got %h exp %h", actv, {7'd64, 7'd64, 7'd64, 3'b001});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    actv = {x, y, z, busy, done, tgt_ready};
    checks++;
    if (actv !== {7'd64, 7'd64, 7'd64, 3'b001}) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", actv, {7'd64, 7'd64, 7'd64, 3'b001});
    end
  endtask

  task automatic test_ramp();
    int dn;
    run_move(70, 60, 64, 0, 0, 0, 1'b0, 1'b0, "ramp", dn);
    checks++;
    if (dn !== 25) begin
      errors++;
      $display("FAIL ramp_done_edge got %0d exp 25", dn);
    end
  endtask

  task automatic test_zero_move();
    int dn;
    run_move(cur[0], cur[1], cur[2], 0, 0, 0, 1'b0, 1'b0, "zero", dn);
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL zero_done_edge got %0d exp 1", dn);
    end
  endtask

  task automatic test_hold_and_ignored_valid();
    int dn;
    run_move(64, 64, 64, 0, 0, 0, 1'b0, 1'b0, "home", dn);
    run_move(70, 60, 64, 8, 10, 0, 1'b1, 1'b0, "hold", dn);
    checks++;
    if (dn !== 35) begin
      errors++;
      $display("FAIL hold_done_edge got %0d exp 35", dn);
    end
    checks++;
    if ({x, y, z} !== {7'd70, 7'd60, 7'd64}) begin
      errors++;
      $display("FAIL hold_final_pose got %0d,%0d,%0d exp 70,60,64", x, y, z);
    end
  endtask

  task automatic test_clamp();
    int dn;
    run_move(64, 64, 64, 0, 0, 0, 1'b0, 1'b0, "home2", dn);
    run_move(127, 64, 64, 0, 0, 0, 1'b0, 1'b0, "clamp", dn);
    checks++;
    if (dn !== 225) begin
      errors++;
      $display("FAIL clamp_done_edge got %0d exp 225", dn);
    end
    checks++;
    if (x !== 7'd120) begin
      errors++;
      $display("FAIL clamp_final_x got %0d exp 120", x);
    end
  endtask

  task automatic test_back_to_back();
    int dn;
    run_move(118, 62, 66, 0, 0, 0, 1'b0, 1'b0, "b2b_first", dn);
    run_move(116, 64, 64, 0, 0, 0, 1'b0, 1'b1, "b2b_second", dn);
    checks++;
    if (dn !== 9) begin
      errors++;
      $display("FAIL b2b_done_edge got %0d exp 9", dn);
    end
  endtask

  task automatic test_reset_mid_move();
    logic [23:0] actv;
    int dn;
    @(negedge clk);
    tgt_x = 7'd100; tgt_y = 7'd30; tgt_z = 7'd64; tgt_valid = 1'b1;
    @(posedge clk);
    #1 tgt_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    actv = {x, y, z, busy, done, tgt_ready};
    checks++;
    if (actv !== {7'd64, 7'd64, 7'd64, 3'b001}) begin
      errors++;
      $display("FAIL midreset_async got %h exp %h", actv, {7'd64, 7'd64, 7'd64, 3'b001});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL midreset_held cyc %0d busy,done got %b exp 00", k, {busy, done});
      end
    end
    rst = 1'b1;
    cur = '{HOME_A, HOME_A, HOME_A};
    run_move(66, 64, 64, 0, 0, 0, 1'b0, 1'b0, "after_reset", dn);
    checks++;
    if (dn !== 9) begin
      errors++;
      $display("FAIL after_reset_done_edge got %0d exp 9", dn);
    end
  endtask

  task automatic test_random();
    int dn;
    for (int k = 0; k < 6; k++) begin
      run_move($urandom_range(127), $urandom_range(127), $urandom_range(127),
               0, 0, 20, 1'b1, ($urandom_range(1) == 1), "random", dn);
      checks++;
      if (dn < 1) begin
        errors++;
        $display("FAIL random_done_seen got %0d exp >=1", dn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_zero_move();
    test_hold_and_ignored_valid();
    test_clamp();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_ramp_sequencer.md
# servo_ramp_sequencer

Motion sequencer directly upstream of `pwm_servo_control`. It accepts a target (x, y, z) angle triple through a valid/ready handshake. It then ramps the three 7-bit servo commands toward that target one LSB per step tick, so the arm never jumps between poses. The `x`/`y`/`z` outputs drive the identically named inputs of `pwm_servo_control`. `done` tells the upstream controller that the pose is reached.

## Interface
- `STEP_DIV`, default 500000: clock cycles per ramp step (10 ms at 50 MHz); legal range ≥1.
- `HOME`, default 7'd64: reset/park angle for all three axes.
- `ANGLE_MAX`, default 7'd120: upper clamp applied to accepted targets.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `tgt_x`, `tgt_y`, `tgt_z`  in  7 each  requested angles.
- `tgt_valid`  in  1  target triple present.
- `tgt_ready`  out  1  sequencer can accept a target.
- `hold`  in  1  freeze ramp while high.
- `x`, `y`, `z`  out  7 each  current commanded angles, registered.
- `busy`  out  1  move in progress.
- `done`  out  1  one-cycle pulse when a move completes.

## Operation
- States: IDLE, MOVE.
- `tgt_ready` = (state == IDLE), combinational. `busy` = (state == MOVE).
- **Accept.** In IDLE, `tgt_valid && tgt_ready` at a rising edge:
  - latch each target as min(tgt, ANGLE_MAX) into internal target registers;
  - clear the step counter;
  - state <= MOVE.
- **MOVE, per edge, in priority order:**
  1. If x==tx && y==ty && z==tz (registered values): state <= IDLE, `done` <= 1.
  2. Else if `hold`: counter and positions unchanged.
  3. Else if counter == STEP_DIV-1: counter <= 0; each axis steps ±1 toward its own target. An axis already at its target is unchanged.
  4. Else: counter <= counter+1.
- Axes move independently and in parallel. Completion requires all three to match.
- Counter width is $clog2(STEP_DIV), minimum 1 bit. STEP_DIV=1 steps every cycle.
- Unsigned 7-bit arithmetic. Stepping only ever moves toward a target ≤ ANGLE_MAX, so no wrap-around is possible.
- `tgt_valid` during MOVE is ignored. There is no queueing, and the upstream must hold the target until ready.
- `done` defaults to 0 every cycle unless set by rule 1.
- `hold` in IDLE has no effect.

## Timing
- **Reset (rst=0, immediate, no clock needed):**
  - x=y=z=HOME, targets=HOME, counter=0;
  - state IDLE, `done`=0, `busy`=0, `tgt_ready`=1.
- **Accept at edge E0:**
  - `busy` rises after E0, `tgt_ready` falls after E0;
  - first position change occurs at edge E0+STEP_DIV (hold low).
- **Move of N = max |Δ| steps, hold low:**
  - last step at E0+N·STEP_DIV;
  - state IDLE and `done` high after E0+N·STEP_DIV+1, for exactly one cycle;
  - `tgt_ready` high in the same cycle.
- Zero-distance target: `done` after E0+1; `busy` high one cycle.
- Each cycle with `hold` high in MOVE (and positions not equal) delays completion by one cycle.
- The next accept is possible in the same cycle `done` is high.
- Reset asserted mid-move aborts the move:
  - outputs jump to HOME asynchronously;
  - no `done` pulse is issued.

## Test plan
All scenarios use STEP_DIV=4, HOME=64, ANGLE_MAX=120.
- **Reset:** drive rst=0 with no clock, then release. Required: x=y=z=64, `tgt_ready`=1, `busy`=0, `done`=0.
- **Ramp:** accept (70,60,64) at E0. Required:
  - x = 65, 66, … at E0+4, E0+8, …, reaching 70 at E0+24;
  - y reaches 60 at E0+16;
  - z stays 64;
  - `done` pulses one cycle after E0+25; `busy` high from after E0 until then.
- **Zero move:** accept (64,64,64). Required: `busy` high one cycle, `done` pulse after E0+1, `tgt_ready` low only during that MOVE cycle.
- **Clamp:** accept (127,64,64). Required: x ends at 120, never exceeds 120, and `done` arrives after E0+225.
- **Hold and ignored valid:** from the ramp scenario, assert `hold` for 10 cycles mid-move and pulse `tgt_valid` with (0,0,0) during MOVE. Required: completion delayed by exactly 10 cycles, the (0,0,0) target is never taken, and the final pose is (70,60,64).
- **Reset mid-move:** assert rst=0 at E0+10 between clock edges. Required: x,y,z=64 immediately, `busy`=0, no `done`, and a new accept works after release.
